// File: rtl/pc_seq_pkg.sv
// Shared encodings and defaults for the next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    typedef enum logic {
        ST_HANDLER = 1'b0,
        ST_RUN     = 1'b1
    } seq_state_e;

    localparam logic [4:0]  EXC_INT      = 5'd0;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_seq_reg.sv
// Program counter register: async active-low reset to RESET_PC, load when en.
module pc_reg
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_PC;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pc_seq.sv
// Next-PC sequencer and exception controller.
// Optional jr alignment exception enabled by defining PC_ALIGN_CHECK_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic        irq,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        int_ack,
    output logic [4:0]  exc_code
);

    seq_state_e  state;
    logic [31:0] npc;
    logic [31:0] pc_d;
    logic [31:0] jr_target;
    logic        adel;

`ifdef PC_ALIGN_CHECK_EN
    assign jr_target = rs_val;
    assign adel      = (npc_op == NPC_JR) && (rs_val[1:0] != 2'b00);
`else
    assign jr_target = rs_val & 32'hFFFF_FFFC;
    assign adel      = 1'b0;
`endif

    assign pc_plus4   = pc + 32'd4;
    assign in_handler = (state == ST_HANDLER);

    always_comb begin
        npc = pc_plus4;
        case (npc_op_e'(npc_op))
            NPC_SEQ: npc = pc_plus4;
            NPC_BR:  npc = br_taken ? pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00} : pc_plus4;
            NPC_J:   npc = {pc_plus4[31:28], instr_index, 2'b00};
            NPC_JR:  npc = jr_target;
            default: npc = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d = npc;
        if (adel)
            pc_d = EXC_VEC;
        else if (irq && state == ST_RUN)
            pc_d = EXC_VEC;
        else if (eret && state == ST_HANDLER)
            pc_d = epc;
    end

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .d     (pc_d),
        .q     (pc)
    );

    // int_ack clears every edge so it stays a single-cycle pulse even under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            epc      <= '0;
            int_ack  <= 1'b0;
            exc_code <= EXC_INT;
        end else begin
            int_ack <= 1'b0;
            if (!stall) begin
                if (adel) begin
                    epc      <= pc;
                    state    <= ST_HANDLER;
                    exc_code <= EXC_ADEL;
                    int_ack  <= 1'b1;
                end else if (irq && state == ST_RUN) begin
                    epc      <= npc;
                    state    <= ST_HANDLER;
                    exc_code <= EXC_INT;
                    int_ack  <= 1'b1;
                end else if (eret && state == ST_HANDLER) begin
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq (honours PC_ALIGN_CHECK_EN).
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic        irq;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        in_handler;
    logic        int_ack;
    logic [4:0]  exc_code;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_seq #(.RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .npc_op      (npc_op),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .irq         (irq),
        .eret        (eret),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .epc         (epc),
        .in_handler  (in_handler),
        .int_ack     (int_ack),
        .exc_code    (exc_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; npc_op = 2'b00; br_taken = 1'b0;
        imm16 = '0; instr_index = '0; rs_val = '0; irq = 1'b0; eret = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 32'h3000);
        check("rst_pc4", pc_plus4, 32'h3004);
        check("rst_epc", epc, 32'h0);
        check("rst_inh", {31'b0, in_handler}, 32'h0);
        check("rst_ack", {31'b0, int_ack}, 32'h0);
        check("rst_code", {27'b0, exc_code}, 32'h0);
        rst_n = 1'b1;

        tick(); check("seq1", pc, 32'h3004);
        tick(); check("seq2", pc, 32'h3008);
        tick(); check("seq3", pc, 32'h300C);
        tick(); check("seq4", pc, 32'h3010);

        npc_op = 2'b01; br_taken = 1'b1; imm16 = 16'hFFFE;
        tick(); check("br_taken", pc, 32'h300C);
        npc_op = 2'b00;
        tick(); check("seq5", pc, 32'h3010);
        npc_op = 2'b01; br_taken = 1'b0;
        tick(); check("br_not", pc, 32'h3014);
        npc_op = 2'b00;
        tick(); tick(); tick();
        check("seq6", pc, 32'h3020);
        npc_op = 2'b10; instr_index = 26'h0000C10;
        tick(); check("jump", pc, 32'h3040);
        npc_op = 2'b11; rs_val = 32'h3000;
        tick(); check("jr", pc, 32'h3000);

        npc_op = 2'b00; irq = 1'b1;
        tick();
        check("irq_pc", pc, 32'h4180);
        check("irq_epc", epc, 32'h3004);
        check("irq_ack", {31'b0, int_ack}, 32'h1);
        check("irq_inh", {31'b0, in_handler}, 32'h1);
        check("irq_code", {27'b0, exc_code}, 32'h0);
        tick();
        check("hold_pc", pc, 32'h4184);
        check("hold_ack", {31'b0, int_ack}, 32'h0);
        check("hold_epc", epc, 32'h3004);
        eret = 1'b1;
        tick();
        check("eret_pc", pc, 32'h3004);
        check("eret_inh", {31'b0, in_handler}, 32'h0);
        eret = 1'b0;
        tick();
        check("reirq_pc", pc, 32'h4180);
        check("reirq_epc", epc, 32'h3008);
        check("reirq_ack", {31'b0, int_ack}, 32'h1);
        irq = 1'b0; eret = 1'b1;
        tick();
        check("eret2_pc", pc, 32'h3008);
        eret = 1'b0;

        stall = 1'b1; irq = 1'b1;
        tick(); check("stall1_pc", pc, 32'h3008);
        tick(); check("stall2_pc", pc, 32'h3008);
        check("stall_inh", {31'b0, in_handler}, 32'h0);
        stall = 1'b0;
        tick();
        check("unstall_pc", pc, 32'h4180);
        check("unstall_epc", epc, 32'h300C);
        check("unstall_ack", {31'b0, int_ack}, 32'h1);
        irq = 1'b0; eret = 1'b1;
        tick(); check("eret3_pc", pc, 32'h300C);
        eret = 1'b0;

        npc_op = 2'b11; rs_val = 32'h3008;
        tick(); check("jr2", pc, 32'h3008);
        rs_val = 32'h3102;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("adel_pc", pc, 32'h4180);
        check("adel_epc", epc, 32'h3008);
        check("adel_code", {27'b0, exc_code}, 32'h4);
        check("adel_ack", {31'b0, int_ack}, 32'h1);
        npc_op = 2'b00; eret = 1'b1;
        tick(); check("adel_ret", pc, 32'h3008);
        eret = 1'b0;
`else
        check("jr_mask", pc, 32'h3100);
        check("jr_inh", {31'b0, in_handler}, 32'h0);
        npc_op = 2'b00; eret = 1'b1;
        tick(); check("eret_run", pc, 32'h3104);
        check("eret_run_inh", {31'b0, in_handler}, 32'h0);
        eret = 1'b0;
`endif

        irq = 1'b1;
        tick();
        check("pre_rst_inh", {31'b0, in_handler}, 32'h1);
        irq = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h3000);
        check("arst_inh", {31'b0, in_handler}, 32'h0);
        check("arst_epc", epc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
